ram_port_arbiter: RTL and testbench

//  Shares one 16-word x 8-bit two-port RAM (one write port, one registered read port) between two requesters, A and B.

---
 rtl/ram_port_arbiter.sv | 86 ++++++++
 tb/tb_ram_port_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter for a 1W/1R RAM: independent round-robin write and read
// grants, with registered read-data return tagged to the owning requester.
module ram_port_arbiter #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              a_req,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_gnt,
   output logic              a_rvalid,
   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_gnt,
   output logic              b_rvalid,
   output logic [DATA_W-1:0] rdata,
   output logic              ram_wen,
   output logic [ADDR_W-1:0] ram_write_addr,
   output logic [DATA_W-1:0] ram_data_in,
   output logic [ADDR_W-1:0] ram_read_addr,
   input  logic [DATA_W-1:0] ram_data_out
);

   localparam logic PRI_A = 1'b0;
   localparam logic PRI_B = 1'b1;

   logic       r_wr_pri;
   logic       r_rd_pri;
   logic [1:0] r_rd_own;   // [0]=A, [1]=B; owner of the read issued last cycle

   logic w_wc_a, w_wc_b, w_rc_a, w_rc_b;
   logic w_wg_a, w_wg_b, w_rg_a, w_rg_b;

   assign w_wc_a = a_req &  a_we;
   assign w_wc_b = b_req &  b_we;
   assign w_rc_a = a_req & ~a_we;
   assign w_rc_b = b_req & ~b_we;

   // Grants are suppressed during reset so nothing reaches the RAM or rd_own.
   assign w_wg_a = ~reset & w_wc_a & (~w_wc_b | (r_wr_pri == PRI_A));
   assign w_wg_b = ~reset & w_wc_b & (~w_wc_a | (r_wr_pri == PRI_B));
   assign w_rg_a = ~reset & w_rc_a & (~w_rc_b | (r_rd_pri == PRI_A));
   assign w_rg_b = ~reset & w_rc_b & (~w_rc_a | (r_rd_pri == PRI_B));

   assign a_gnt    = w_wg_a | w_rg_a;
   assign b_gnt    = w_wg_b | w_rg_b;
   assign a_rvalid = r_rd_own[0];
   assign b_rvalid = r_rd_own[1];
   assign rdata    = ram_data_out;

   always_comb begin
      ram_wen        = w_wg_a | w_wg_b;
      ram_write_addr = '0;
      ram_data_in    = '0;
      ram_read_addr  = '0;
      if (w_wg_a) begin
         ram_write_addr = a_addr;
         ram_data_in    = a_wdata;
      end else if (w_wg_b) begin
         ram_write_addr = b_addr;
         ram_data_in    = b_wdata;
      end
      if (w_rg_a)      ram_read_addr = a_addr;
      else if (w_rg_b) ram_read_addr = b_addr;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_pri <= PRI_A;
         r_rd_pri <= PRI_A;
         r_rd_own <= 2'b00;
      end else begin
         if (w_wg_a)      r_wr_pri <= PRI_B;
         else if (w_wg_b) r_wr_pri <= PRI_A;
         if (w_rg_a)      r_rd_pri <= PRI_B;
         else if (w_rg_b) r_rd_pri <= PRI_A;
         r_rd_own <= {w_rg_b, w_rg_a};
      end
   end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural read-before-write RAM.
module tb_ram_port_arbiter;
   logic       clk = 1'b0;
   logic       reset;
   logic       a_req, a_we, b_req, b_we;
   logic [3:0] a_addr, b_addr;
   logic [7:0] a_wdata, b_wdata;
   logic       a_gnt, a_rvalid, b_gnt, b_rvalid;
   logic [7:0] rdata, ram_data_in, ram_data_out;
   logic       ram_wen;
   logic [3:0] ram_write_addr, ram_read_addr;
   logic [7:0] mem [16];
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      ram_data_out <= mem[ram_read_addr];
      if (ram_wen) mem[ram_write_addr] <= ram_data_in;
   end

   ram_port_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
      .clk(clk), .reset(reset),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_gnt(a_gnt), .a_rvalid(a_rvalid),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_gnt(b_gnt), .b_rvalid(b_rvalid),
      .rdata(rdata), .ram_wen(ram_wen), .ram_write_addr(ram_write_addr),
      .ram_data_in(ram_data_in), .ram_read_addr(ram_read_addr),
      .ram_data_out(ram_data_out)
   );

   task automatic idle();
      a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
      b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
   endtask

   task automatic next_cycle();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      @(posedge clk); #1;
      reset = 1;
      a_req = 1; a_we = 0; b_req = 1; b_we = 1;
      @(negedge clk);
      checks++;
      if ({a_gnt, b_gnt, ram_wen, a_rvalid, b_rvalid} !== 5'b0) begin
         errors++;
         $display("FAIL reset_outputs: got gnt=%b%b wen=%b rv=%b%b required all 0",
                  a_gnt, b_gnt, ram_wen, a_rvalid, b_rvalid);
      end
      checks++;
      if ({ram_write_addr, ram_data_in, ram_read_addr} !== 16'h0) begin
         errors++;
         $display("FAIL reset_ram_bus: got wa=%h wd=%h ra=%h required 0",
                  ram_write_addr, ram_data_in, ram_read_addr);
      end
      next_cycle();
      idle();
      reset = 0;
   endtask

   task automatic test_write();
      a_req = 1; a_we = 1; a_addr = 4'h0; a_wdata = 8'h70;
      @(negedge clk);
      checks++;
      if ({a_gnt, b_gnt, ram_wen, ram_write_addr, ram_data_in} !== {3'b101, 4'h0, 8'h70}) begin
         errors++;
         $display("FAIL write_a: got gnt=%b%b wen=%b wa=%h wd=%h required gnt=10 wen=1 wa=0 wd=70",
                  a_gnt, b_gnt, ram_wen, ram_write_addr, ram_data_in);
      end
      next_cycle();
      idle();
   endtask

   task automatic test_read();
      a_req = 1; a_we = 0; a_addr = 4'h0;
      @(negedge clk);
      checks++;
      if ({a_gnt, ram_read_addr, a_rvalid, ram_wen} !== {1'b1, 4'h0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL read_a_grant: got gnt=%b ra=%h rv=%b wen=%b required 1 0 0 0",
                  a_gnt, ram_read_addr, a_rvalid, ram_wen);
      end
      next_cycle();
      idle();
      @(negedge clk);
      checks++;
      if ({a_rvalid, b_rvalid, rdata} !== {2'b10, 8'h70}) begin
         errors++;
         $display("FAIL read_a_data: got rv=%b%b rdata=%h required rv=10 rdata=70",
                  a_rvalid, b_rvalid, rdata);
      end
      next_cycle();
      @(negedge clk);
      checks++;
      if ({a_rvalid, b_rvalid} !== 2'b00) begin
         errors++;
         $display("FAIL read_a_single_pulse: got rv=%b%b required 00", a_rvalid, b_rvalid);
      end
   endtask

   task automatic test_write_contention();
      logic [1:0] exp;
      test_reset();
      a_req = 1; a_we = 1; a_addr = 4'h1; a_wdata = 8'h11;
      b_req = 1; b_we = 1; b_addr = 4'h2; b_wdata = 8'h22;
      for (int i = 0; i < 4; i++) begin
         exp = (i % 2 == 0) ? 2'b10 : 2'b01;
         @(negedge clk);
         checks++;
         if ({a_gnt, b_gnt} !== exp) begin
            errors++;
            $display("FAIL wr_contention_gnt[%0d]: got %b%b required %b", i, a_gnt, b_gnt, exp);
         end
         checks++;
         if ({ram_wen, ram_write_addr, ram_data_in} !==
             ((i % 2 == 0) ? {1'b1, 4'h1, 8'h11} : {1'b1, 4'h2, 8'h22})) begin
            errors++;
            $display("FAIL wr_contention_bus[%0d]: got wen=%b wa=%h wd=%h", i,
                     ram_wen, ram_write_addr, ram_data_in);
         end
         next_cycle();
      end
      idle();
   endtask

   task automatic test_rw_same_addr();
      b_req = 1; b_we = 1; b_addr = 4'h5; b_wdata = 8'h33;
      next_cycle();
      idle();
      a_req = 1; a_we = 1; a_addr = 4'h5; a_wdata = 8'h55;
      b_req = 1; b_we = 0; b_addr = 4'h5;
      @(negedge clk);
      checks++;
      if ({a_gnt, b_gnt, ram_wen, ram_write_addr, ram_read_addr} !== {3'b111, 4'h5, 4'h5}) begin
         errors++;
         $display("FAIL rw_same_grant: got gnt=%b%b wen=%b wa=%h ra=%h required 11 1 5 5",
                  a_gnt, b_gnt, ram_wen, ram_write_addr, ram_read_addr);
      end
      next_cycle();
      idle();
      b_req = 1; b_we = 0; b_addr = 4'h5;
      @(negedge clk);
      checks++;
      if ({a_rvalid, b_rvalid, rdata} !== {2'b01, 8'h33}) begin
         errors++;
         $display("FAIL rw_same_old_data: got rv=%b%b rdata=%h required rv=01 rdata=33",
                  a_rvalid, b_rvalid, rdata);
      end
      next_cycle();
      idle();
      @(negedge clk);
      checks++;
      if ({b_rvalid, rdata} !== {1'b1, 8'h55}) begin
         errors++;
         $display("FAIL rw_same_new_data: got rv=%b rdata=%h required rv=1 rdata=55",
                  b_rvalid, rdata);
      end
      next_cycle();
   endtask

   task automatic test_reset_mid_read();
      // Push both priorities to PRI_B first so the reset has something to undo.
      a_req = 1; a_we = 1; a_addr = 4'hF; a_wdata = 8'hF0;
      next_cycle();
      a_we = 0; a_addr = 4'h1;
      next_cycle();
      idle();
      a_req = 1; a_we = 0; a_addr = 4'h3;
      @(negedge clk);
      reset = 1;
      #1;
      checks++;
      if ({a_gnt, ram_wen, ram_read_addr, ram_write_addr, ram_data_in} !== 18'h0) begin
         errors++;
         $display("FAIL reset_mid_read_bus: got gnt=%b wen=%b ra=%h wa=%h wd=%h required 0",
                  a_gnt, ram_wen, ram_read_addr, ram_write_addr, ram_data_in);
      end
      next_cycle();
      @(negedge clk);
      checks++;
      if ({a_rvalid, b_rvalid} !== 2'b00) begin
         errors++;
         $display("FAIL reset_mid_read_rvalid: got %b%b required 00", a_rvalid, b_rvalid);
      end
      reset = 0;
      a_req = 1; a_we = 1; b_req = 1; b_we = 1;
      #1;
      checks++;
      if ({a_gnt, b_gnt} !== 2'b10) begin
         errors++;
         $display("FAIL reset_wr_pri: got %b%b required 10", a_gnt, b_gnt);
      end
      a_we = 0; b_we = 0;
      #1;
      checks++;
      if ({a_gnt, b_gnt} !== 2'b10) begin
         errors++;
         $display("FAIL reset_rd_pri: got %b%b required 10", a_gnt, b_gnt);
      end
      idle();
      next_cycle();
   endtask

   task automatic test_read_stream();
      test_reset();
      a_req = 1; a_we = 0; a_addr = 4'hF;
      b_req = 1; b_we = 0; b_addr = 4'h1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++;
         if ({a_gnt, b_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
            errors++;
            $display("FAIL stream_gnt[%0d]: got %b%b", i, a_gnt, b_gnt);
         end
         if (i > 0) begin
            checks++;
            if ({a_rvalid, b_rvalid, rdata} !==
                ((i % 2 == 1) ? {2'b10, 8'hF0} : {2'b01, 8'h11})) begin
               errors++;
               $display("FAIL stream_rvalid[%0d]: got rv=%b%b rdata=%h", i, a_rvalid, b_rvalid, rdata);
            end
         end
         next_cycle();
      end
      idle();
      @(negedge clk);
      checks++;
      if ({a_rvalid, b_rvalid, rdata} !== {2'b01, 8'h11}) begin
         errors++;
         $display("FAIL stream_last: got rv=%b%b rdata=%h required rv=01 rdata=11",
                  a_rvalid, b_rvalid, rdata);
      end
   endtask

   initial begin
      reset = 0;
      idle();
      test_reset();
      test_write();
      test_read();
      test_write_contention();
      test_rw_same_addr();
      test_reset_mid_read();
      test_read_stream();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
